// File: rtl/audio_codec_link.sv
// audio_codec_link: WM8731 master-mode, left-justified stereo sample link.
// Codec pins are synchronised into clk; sample pairs cross via small FIFOs.
module audio_codec_link_fifo #(
    parameter int W     = 24,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic [W-1:0] push_left,
    input  logic [W-1:0] push_right,
    input  logic         pop,
    output logic [W-1:0] head_left,
    output logic [W-1:0] head_right,
    output logic         empty,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_left  [DEPTH];
    logic [W-1:0]  mem_right [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty      = (count == '0);
    assign full       = (count == (AW+1)'(DEPTH));
    assign do_push    = push && !full;
    assign do_pop     = pop && !empty;
    assign head_left  = mem_left[rptr];
    assign head_right = mem_right[rptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_left[i]  <= '0;
                mem_right[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_left[wptr]  <= push_left;
                mem_right[wptr] <= push_right;
                wptr            <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module audio_codec_link #(
    parameter int AUDIO_DATA_WIDTH = 24,
    parameter int FIFO_DEPTH       = 4
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        read,
    output logic                        read_ready,
    output logic [AUDIO_DATA_WIDTH-1:0] readdata_left,
    output logic [AUDIO_DATA_WIDTH-1:0] readdata_right,
    input  logic                        write,
    output logic                        write_ready,
    input  logic [AUDIO_DATA_WIDTH-1:0] writedata_left,
    input  logic [AUDIO_DATA_WIDTH-1:0] writedata_right,
    input  logic                        AUD_BCLK,
    input  logic                        AUD_ADCLRCK,
    input  logic                        AUD_ADCDAT,
    input  logic                        AUD_DACLRCK,
    output logic                        AUD_DACDAT,
    output logic                        overflow,
    output logic                        underflow
);
    localparam int W  = AUDIO_DATA_WIDTH;
    localparam int CW = $clog2(W + 1);

    // {daclrck, adcdat, adclrck, bclk}
    logic [3:0] sync_a;
    logic [3:0] sync_b;
    logic [2:0] last;
    logic       bclk_rise;
    logic       bclk_fall;
    logic       adc_edge;
    logic       dac_rise;
    logic       dac_fall;

    assign bclk_rise = sync_b[0] && !last[0];
    assign bclk_fall = !sync_b[0] && last[0];
    assign adc_edge  = sync_b[1] ^ last[1];
    assign dac_rise  = sync_b[3] && !last[2];
    assign dac_fall  = !sync_b[3] && last[2];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_a <= '0;
            sync_b <= '0;
            last   <= '0;
        end else begin
            sync_a <= {AUD_DACLRCK, AUD_ADCDAT, AUD_ADCLRCK, AUD_BCLK};
            sync_b <= sync_a;
            last   <= {sync_b[3], sync_b[1], sync_b[0]};
        end
    end

    logic [CW-1:0] rx_count;
    logic          rx_chan;
    logic          rx_armed;
    logic [W-1:0]  rx_shift;
    logic [W-1:0]  rx_left;
    logic [W-1:0]  rx_word;
    logic          rx_bit;
    logic          rx_last;
    logic          rx_push;
    logic          in_empty;
    logic          in_full;

    assign rx_word = {rx_shift[W-2:0], sync_b[2]};
    assign rx_bit  = bclk_rise && !adc_edge && (rx_count != CW'(W));
    assign rx_last = rx_bit && (rx_count == CW'(W - 1));
    assign rx_push = rx_last && !rx_chan && rx_armed;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_count <= '0;
            rx_chan  <= 1'b0;
            rx_armed <= 1'b0;
            rx_shift <= '0;
            rx_left  <= '0;
            overflow <= 1'b0;
        end else begin
            if (adc_edge) begin
                rx_count <= '0;
                rx_chan  <= sync_b[1];
            end else if (rx_bit) begin
                rx_shift <= rx_word;
                rx_count <= rx_count + 1'b1;
                if (rx_last && rx_chan) begin
                    rx_left  <= rx_word;
                    rx_armed <= 1'b1;
                end else if (rx_last) begin
                    rx_armed <= 1'b0;
                end
            end
            if (rx_push && in_full) begin
                overflow <= 1'b1;
            end
        end
    end

    audio_codec_link_fifo #(.W(W), .DEPTH(FIFO_DEPTH)) u_in_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (rx_push),
        .push_left  (rx_left),
        .push_right (rx_word),
        .pop        (read),
        .head_left  (readdata_left),
        .head_right (readdata_right),
        .empty      (in_empty),
        .full       (in_full)
    );

    assign read_ready = !in_empty;

    logic [W-1:0] out_left;
    logic [W-1:0] out_right;
    logic         out_empty;
    logic         out_full;
    logic [W-1:0] tx_shift;
    logic [W-1:0] tx_right;
    logic         tx_armed;

    audio_codec_link_fifo #(.W(W), .DEPTH(FIFO_DEPTH)) u_out_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (write),
        .push_left  (writedata_left),
        .push_right (writedata_right),
        .pop        (dac_rise),
        .head_left  (out_left),
        .head_right (out_right),
        .empty      (out_empty),
        .full       (out_full)
    );

    assign write_ready = !out_full;

    // Shifting zeros in behind the word makes the line idle low after the LSB.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_shift   <= '0;
            tx_right   <= '0;
            tx_armed   <= 1'b0;
            AUD_DACDAT <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            if (dac_rise) begin
                tx_armed <= 1'b1;
                if (out_empty) begin
                    {AUD_DACDAT, tx_shift} <= '0;
                    tx_right               <= '0;
                    underflow              <= 1'b1;
                end else begin
                    {AUD_DACDAT, tx_shift} <= {out_left, 1'b0};
                    tx_right               <= out_right;
                end
            end else if (dac_fall && tx_armed) begin
                {AUD_DACDAT, tx_shift} <= {tx_right, 1'b0};
            end else if (bclk_fall) begin
                {AUD_DACDAT, tx_shift} <= {tx_shift, 1'b0};
            end
        end
    end
endmodule

// File: tb/tb_audio_codec_link.sv
// Bench for audio_codec_link: codec master model drives frames while
// scoreboard queues hold expected ADC pairs and DAC pairs.
`timescale 1ns/1ps
module tb_audio_codec_link;
    localparam int W = 24;

    typedef struct packed {
        logic [W-1:0] l;
        logic [W-1:0] r;
    } pair_t;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         read;
    logic         read_ready;
    logic [W-1:0] readdata_left;
    logic [W-1:0] readdata_right;
    logic         write;
    logic         write_ready;
    logic [W-1:0] writedata_left;
    logic [W-1:0] writedata_right;
    logic         AUD_BCLK;
    logic         AUD_ADCLRCK;
    logic         AUD_ADCDAT;
    logic         AUD_DACLRCK;
    logic         AUD_DACDAT;
    logic         overflow;
    logic         underflow;

    always #5 clk = ~clk;

    audio_codec_link #(.AUDIO_DATA_WIDTH(W), .FIFO_DEPTH(4)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .read            (read),
        .read_ready      (read_ready),
        .readdata_left   (readdata_left),
        .readdata_right  (readdata_right),
        .write           (write),
        .write_ready     (write_ready),
        .writedata_left  (writedata_left),
        .writedata_right (writedata_right),
        .AUD_BCLK        (AUD_BCLK),
        .AUD_ADCLRCK     (AUD_ADCLRCK),
        .AUD_ADCDAT      (AUD_ADCDAT),
        .AUD_DACLRCK     (AUD_DACLRCK),
        .AUD_DACDAT      (AUD_DACDAT),
        .overflow        (overflow),
        .underflow       (underflow)
    );

    int    checks = 0;
    int    errors = 0;
    pair_t rx_exp[$];
    pair_t dac_fifo[$];
    pair_t dac_exp[$];
    bit    rx_auto = 1'b0;
    bit    dac_on  = 1'b0;
    bit    exp_ovf = 1'b0;
    bit    exp_unf = 1'b0;

    function automatic void chk(string name, logic [47:0] got, logic [47:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endfunction

    // ADC-side monitor: pops whenever the DUT presents a pair
    initial begin
        pair_t e;
        read = 1'b0;
        forever begin
            @(negedge clk);
            read = 1'b0;
            if (rx_auto && read_ready) begin
                if (rx_exp.size() == 0) begin
                    chk("rx_unexpected", {readdata_left, readdata_right}, 48'hx);
                end else begin
                    e = rx_exp.pop_front();
                    chk("rx_pair", {readdata_left, readdata_right}, e);
                end
                read = 1'b1;
            end
        end
    end

    // DAC-side monitor: codec samples DACDAT on BCLK rising edges
    initial begin
        int           bits;
        logic         lr_last;
        logic [W-1:0] sh;
        logic [W-1:0] capl;
        bit           have_l;
        pair_t        e;
        bits    = 0;
        lr_last = 1'b0;
        sh      = '0;
        capl    = '0;
        have_l  = 1'b0;
        forever begin
            @(posedge AUD_BCLK);
            if (AUD_DACLRCK !== lr_last) begin
                bits    = 0;
                lr_last = AUD_DACLRCK;
                if (lr_last) have_l = 1'b0;
            end
            if (!dac_on) begin
                have_l = 1'b0;
            end else if (bits < W) begin
                sh = {sh[W-2:0], AUD_DACDAT};
                bits++;
                if (bits == W && lr_last) begin
                    capl   = sh;
                    have_l = 1'b1;
                end else if (bits == W && have_l) begin
                    have_l = 1'b0;
                    if (dac_exp.size() == 0) begin
                        chk("dac_unexpected", {capl, sh}, 48'hx);
                    end else begin
                        e = dac_exp.pop_front();
                        chk("dac_pair", {capl, sh}, e);
                    end
                end
            end else begin
                chk("dac_tail_zero", AUD_DACDAT, 0);
                bits++;
            end
        end
    end

    // One stereo frame on both ADC and DAC sides; nb BCLKs per word.
    task automatic frame(input logic [W-1:0] l, input logic [W-1:0] r,
                         input int nb, input int rst_bit = -1,
                         input int rel_bit = -1);
        pair_t        dp;
        logic [W-1:0] w;
        if (rst_bit < 0) begin
            if (dac_fifo.size() > 0) begin
                dp = dac_fifo.pop_front();
            end else begin
                dp      = '0;
                exp_unf = 1'b1;
            end
            dac_exp.push_back(dp);
        end
        for (int ch = 0; ch < 2; ch++) begin
            w = (ch == 0) ? l : r;
            for (int i = 0; i < nb; i++) begin
                AUD_BCLK = 1'b0;
                if (i == 0) begin
                    AUD_ADCLRCK = (ch == 0);
                    AUD_DACLRCK = (ch == 0);
                end
                AUD_ADCDAT = (i < W) ? w[W-1-i] : 1'b1;
                if (ch == 0 && i == rst_bit) begin
                    reset_n = 1'b0;
                    rx_exp.delete();
                    dac_fifo.delete();
                    exp_ovf = 1'b0;
                    exp_unf = 1'b0;
                end
                if (ch == 1 && i == rel_bit) reset_n = 1'b1;
                #40;
                AUD_BCLK = 1'b1;
                if (ch == 1 && i == W - 1 && rst_bit < 0) begin
                    if (rx_exp.size() < 4) rx_exp.push_back({l, r});
                    else exp_ovf = 1'b1;
                end
                #40;
            end
        end
    endtask

    task automatic wr(input pair_t p);
        @(negedge clk);
        chk("write_ready", write_ready, dac_fifo.size() < 4);
        writedata_left  = p.l;
        writedata_right = p.r;
        write           = 1'b1;
        @(negedge clk);
        write = 1'b0;
        if (dac_fifo.size() < 4) dac_fifo.push_back(p);
    endtask

    task automatic drain_rx();
        for (int i = 0; i < 200 && rx_exp.size() != 0; i++) @(negedge clk);
        chk("rx_drain_left", rx_exp.size(), 0);
    endtask

    task automatic chk_flags(string name);
        chk({name, "_overflow"}, overflow, exp_ovf);
        chk({name, "_underflow"}, underflow, exp_unf);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        pair_t p;
        reset_n         = 1'b0;
        write           = 1'b0;
        writedata_left  = '0;
        writedata_right = '0;
        AUD_BCLK        = 1'b1;
        AUD_ADCLRCK     = 1'b0;
        AUD_ADCDAT      = 1'b0;
        AUD_DACLRCK     = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_read_ready", read_ready, 0);
        chk("rst_write_ready", write_ready, 1);
        chk("rst_readdata", {readdata_left, readdata_right}, 0);
        chk("rst_dacdat", AUD_DACDAT, 0);
        chk_flags("rst");
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        dac_on = 1'b1;

        // loopback
        frame(24'h123456, 24'hABCDEF, W);
        chk("rx_latency", read_ready, 1);
        rx_auto = 1'b1;
        wr('{l: 24'h123456, r: 24'hABCDEF});
        frame(24'h000001, 24'hFFFFFE, W);
        drain_rx();
        rx_auto = 1'b0;
        chk_flags("loopback");

        // input overflow
        frame(24'h111111, 24'h222222, W);
        frame(24'h333333, 24'h444444, W);
        frame(24'h555555, 24'h666666, W);
        frame(24'h777777, 24'h888888, W);
        frame(24'h999999, 24'hAAAAAA, W);
        chk("ovf_read_ready", read_ready, 1);
        chk_flags("overflow");
        rx_auto = 1'b1;
        drain_rx();

        // output underflow, then extreme values
        frame(24'h0F0F0F, 24'hF0F0F0, W);
        frame(24'h800001, 24'h7FFFFE, W);
        chk_flags("underflow");
        wr('{l: 24'h800000, r: 24'h7FFFFF});
        frame(24'h000000, 24'hFFFFFF, W);

        // full output FIFO and same-cycle pop/push
        wr('{l: 24'hA00001, r: 24'hB00001});
        wr('{l: 24'hA00002, r: 24'hB00002});
        wr('{l: 24'hA00003, r: 24'hB00003});
        wr('{l: 24'hA00004, r: 24'hB00004});
        @(negedge clk);
        chk("full_write_ready", write_ready, 0);
        wr('{l: 24'hDEAD00, r: 24'hBEEF00});
        p = '{l: 24'h0A0B0C, r: 24'h0D0E0F};
        fork
            frame(24'h123123, 24'h456456, W);
            begin
                @(posedge clk);
                @(posedge clk);
                @(negedge clk);
                writedata_left  = p.l;
                writedata_right = p.r;
                write           = 1'b1;
                chk("pop_edge_write_ready", write_ready, 0);
                @(negedge clk);
                chk("after_pop_write_ready", write_ready, 1);
                @(negedge clk);
                write = 1'b0;
                chk("refilled_write_ready", write_ready, 0);
                dac_fifo.push_back(p);
            end
        join
        for (int i = 0; i < 4; i++) frame(24'h010203 + 24'(i), 24'h040506, W);
        drain_rx();

        // reset mid-word
        dac_on = 1'b0;
        frame(24'h5A5A5A, 24'hA5A5A5, W, 10, 8);
        @(negedge clk);
        chk("midrst_read_ready", read_ready, 0);
        chk("midrst_write_ready", write_ready, 1);
        chk("midrst_dacdat", AUD_DACDAT, 0);
        chk_flags("midrst");
        dac_on = 1'b1;
        frame(24'h13579B, 24'h2468AC, W);
        drain_rx();
        chk_flags("postrst");

        // 32 BCLKs per word
        wr('{l: 24'h5A5A5A, r: 24'hC3C3C3});
        frame(24'hF0F0F0, 24'h0F0F0F, 32);
        drain_rx();
        chk_flags("long_word");

        for (int i = 0; i < 50 && dac_exp.size() != 0; i++) @(negedge clk);
        chk("dac_drain_left", dac_exp.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
